// File: rtl/obi_traffic_gen.sv
// obi_traffic_gen
//   Single-port OBI manager that writes a pattern over an address window and
//   then reads the window back and verifies it. At most NumMaxTrans transfers
//   are outstanding at any time. Errors are counted in a saturating counter.
//
// Optional feature macro: OBI_TRAFFIC_GEN_RREADY_BP_EN
//   Defined   : rready_o follows bit 0 of a free-running 16-bit LFSR
//               (seed 16'hACE1), which back-pressures responses.
//   Undefined : rready_o is tied to 1.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i, num_req_i begin a run of num_req_i transfers per pass
//   busy_o, done_o     run status; done_o is held until the next start_i
//   err_cnt_o          saturating error count, cleared on start_i
//   req_o .. aid_o     OBI A channel (request side)
//   gnt_i              OBI grant
//   rvalid_i .. err_i  OBI R channel; rready_o is the response ready
//
// State   | meaning
// IDLE    | no run since reset
// WRITE   | issuing write transfers
// WDRAIN  | all writes issued, waiting for outstanding responses
// READ    | issuing read transfers
// RDRAIN  | all reads issued, waiting for outstanding responses
// DONE    | run complete, results held
module obi_traffic_gen #(
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          IdWidth     = 5,
  parameter int unsigned          NumMaxTrans = 8,
  parameter logic [AddrWidth-1:0] MinAddr     = 32'h0000_0000,
  parameter logic [AddrWidth-1:0] MaxAddr     = 32'h0001_3000,
  parameter logic [31:0]          DataSeed    = 32'hA5A5_5A5A
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [31:0]            num_req_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [15:0]            err_cnt_o,
  output logic                   req_o,
  input  logic                   gnt_i,
  output logic [AddrWidth-1:0]   addr_o,
  output logic                   we_o,
  output logic [DataWidth/8-1:0] be_o,
  output logic [DataWidth-1:0]   wdata_o,
  output logic [IdWidth-1:0]     aid_o,
  input  logic                   rvalid_i,
  output logic                   rready_o,
  input  logic [DataWidth-1:0]   rdata_i,
  input  logic [IdWidth-1:0]     rid_i,
  input  logic                   err_i
);

  localparam int unsigned Step     = DataWidth / 8;
  localparam int unsigned PtrWidth = $clog2(NumMaxTrans);
  localparam int unsigned CntWidth = PtrWidth + 1;

  typedef enum logic [2:0] {
    IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            num_req_q;
  logic [31:0]            issued_q, issued_d, issued_base;
  logic [31:0]            num_base;
  logic [AddrWidth-1:0]   addr_q, addr_d, addr_adv;
  logic [AddrWidth:0]     addr_sum;
  logic                   we_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [IdWidth-1:0]     aid_q;
  logic                   req_q, req_d;
  logic [CntWidth-1:0]    outst_q, outst_d;
  logic [15:0]            err_cnt_q;

  logic [AddrWidth-1:0]   fifo_addr_q [NumMaxTrans];
  logic [IdWidth-1:0]     fifo_aid_q  [NumMaxTrans];
  logic [PtrWidth-1:0]    wr_ptr_q, rd_ptr_q;

  logic xfer, resp, pop, fifo_empty;
  logic load_run, load_read, issuing_d;
  logic active, rd_pass, err_hit;

  // Write pattern: zero-extended address XOR the seed replicated over the bus.
  function automatic logic [DataWidth-1:0] pattern(input logic [AddrWidth-1:0] a);
    logic [DataWidth-1:0] seed_rep;
    for (int i = 0; i < int'(DataWidth); i++) seed_rep[i] = DataSeed[i % 32];
    return DataWidth'(a) ^ seed_rep;
  endfunction

`ifdef OBI_TRAFFIC_GEN_RREADY_BP_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign rready_o = lfsr_q[0];
`else
  assign rready_o = 1'b1;
`endif

  assign xfer       = req_q & gnt_i;
  assign resp       = rvalid_i & rready_o;
  assign fifo_empty = (outst_q == '0);
  // A response with nothing outstanding is never popped; it only counts as an error.
  assign pop        = resp & ~fifo_empty;
  assign outst_d    = outst_q + CntWidth'(xfer) - CntWidth'(pop);
  assign issued_d   = issued_q + 32'(xfer);

  assign addr_sum = {1'b0, addr_q} + (AddrWidth+1)'(Step);
  assign addr_adv = (addr_sum >= {1'b0, MaxAddr}) ? MinAddr : addr_sum[AddrWidth-1:0];

  assign active  = (state_q == WRITE) || (state_q == WDRAIN) ||
                   (state_q == READ)  || (state_q == RDRAIN);
  assign rd_pass = (state_q == READ) || (state_q == RDRAIN);

  always_comb begin
    state_d   = state_q;
    load_run  = 1'b0;
    load_read = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          load_run = 1'b1;
          state_d  = (num_req_i == '0) ? DONE : WRITE;
        end
      end
      WRITE:  if (issued_d == num_req_q) state_d = WDRAIN;
      WDRAIN: begin
        if (outst_d == '0) begin
          state_d   = READ;
          load_read = 1'b1;
        end
      end
      READ:   if (issued_d == num_req_q) state_d = RDRAIN;
      RDRAIN: if (outst_d == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Request is registered from next-cycle counts, so rvalid_i never reaches
  // req_o combinationally while a same-cycle response still frees a slot.
  always_comb begin
    issuing_d   = (state_d == WRITE) || (state_d == READ);
    issued_base = (load_run || load_read) ? '0 : issued_d;
    num_base    = load_run ? num_req_i : num_req_q;
    req_d       = issuing_d && (issued_base < num_base) &&
                  (outst_d < CntWidth'(NumMaxTrans));
    addr_d      = (load_run || load_read) ? MinAddr : (xfer ? addr_adv : addr_q);
  end

  always_comb begin
    err_hit = 1'b0;
    if (resp && active) begin
      if (fifo_empty) begin
        err_hit = 1'b1;
      end else begin
        err_hit = err_i || (rid_i != fifo_aid_q[rd_ptr_q]) ||
                  (rd_pass && (rdata_i != pattern(fifo_addr_q[rd_ptr_q])));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      num_req_q <= '0;
      issued_q  <= '0;
      addr_q    <= MinAddr;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      aid_q     <= '0;
      req_q     <= 1'b0;
      outst_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      outst_q  <= outst_d;
      issued_q <= issued_base;
      aid_q    <= issued_base[IdWidth-1:0];
      addr_q   <= addr_d;
      if (load_run || load_read || xfer) wdata_q <= pattern(addr_d);
      if (load_run)  begin
        num_req_q <= num_req_i;
        we_q      <= 1'b1;
      end
      if (load_read) we_q <= 1'b0;
      if (xfer) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      if (load_run)                         err_cnt_q <= '0;
      else if (err_hit && err_cnt_q != '1)  err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (xfer) begin
      fifo_addr_q[wr_ptr_q] <= addr_q;
      fifo_aid_q[wr_ptr_q]  <= aid_q;
    end
  end

  assign busy_o    = active;
  assign done_o    = (state_q == DONE);
  assign err_cnt_o = err_cnt_q;
  assign req_o     = req_q;
  assign addr_o    = addr_q;
  assign we_o      = we_q;
  assign be_o      = '1;
  assign wdata_o   = wdata_q;
  assign aid_o     = aid_q;

endmodule

// File: tb/tb_obi_traffic_gen.sv
module tb_obi_traffic_gen;
  localparam logic [31:0] SEED = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, start_i;
  logic [31:0] num_req_i;
  logic        busy_o, done_o, req_o, we_o, rready_o;
  logic [15:0] err_cnt_o;
  logic        gnt_i = 1'b0, rvalid_i = 1'b0, err_i = 1'b0;
  logic [31:0] addr_o, wdata_o, rdata_i = '0;
  logic [3:0]  be_o;
  logic [4:0]  aid_o, rid_i = '0;

  logic        start_w;
  logic [31:0] num_req_w;
  logic        busy_w, done_w, req_w, we_w, rready_w;
  logic [15:0] err_w_cnt;
  logic        rvalid_w = 1'b0;
  logic [31:0] addr_w, wdata_w, rdata_w = '0;
  logic [3:0]  be_w;
  logic [4:0]  aid_w, rid_w = '0;

  obi_traffic_gen dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_req_i(num_req_i),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
    .wdata_o(wdata_o), .aid_o(aid_o), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .rdata_i(rdata_i), .rid_i(rid_i), .err_i(err_i)
  );

  obi_traffic_gen #(.MinAddr(32'h100), .MaxAddr(32'h110)) dut_w (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_w), .num_req_i(num_req_w),
    .busy_o(busy_w), .done_o(done_w), .err_cnt_o(err_w_cnt),
    .req_o(req_w), .gnt_i(1'b1), .addr_o(addr_w), .we_o(we_w), .be_o(be_w),
    .wdata_o(wdata_w), .aid_o(aid_w), .rvalid_i(rvalid_w), .rready_o(rready_w),
    .rdata_i(rdata_w), .rid_i(rid_w), .err_i(1'b0)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model for the main instance: 1-cycle response latency
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [4:0]  aid;
  } xfer_t;

  xfer_t       q[$];
  xfer_t       p, h;
  logic        pend = 1'b0;
  logic [31:0] mem [256];
  logic [31:0] log_addr [64];
  logic        log_we [64];
  logic [4:0]  log_aid [64];
  logic [31:0] log_wdata [64];
  int          n_x = 0;
  int          last_rsp_cyc = 0;
  logic        gnt_en = 1'b1, rsp_en = 1'b1;
  logic        corrupt_en = 1'b0, err_wr_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h8, err_addr = 32'h4;

  always @(negedge clk) begin
    if (pend) begin
      if (p.we) mem[p.addr[9:2]] = p.wdata;
      q.push_back(p);
      if (n_x < 64) begin
        log_addr[n_x] = p.addr; log_we[n_x] = p.we;
        log_aid[n_x] = p.aid;   log_wdata[n_x] = p.wdata;
      end
      n_x++;
    end
    if (rsp_en && q.size() > 0) begin
      h = q.pop_front();
      rvalid_i = 1'b1;
      rid_i    = h.aid;
      err_i    = err_wr_en && h.we && (h.addr == err_addr);
      rdata_i  = h.we ? 32'h0 :
                 (mem[h.addr[9:2]] ^ ((corrupt_en && h.addr == corrupt_addr) ? 32'h1 : 32'h0));
      last_rsp_cyc = cyc;
    end else begin
      rvalid_i = 1'b0;
      err_i    = 1'b0;
    end
    gnt_i = gnt_en;
    pend  = req_o && gnt_en && !rst_i;
    p     = '{addr_o, we_o, wdata_o, aid_o};
  end

  // window instance model: always granted, always correct data
  logic        pend_w = 1'b0;
  logic [31:0] pw_addr = '0;
  logic [4:0]  pw_aid = '0;
  logic [31:0] log_w [8];
  int          n_w = 0;

  always @(negedge clk) begin
    rvalid_w = pend_w;
    rid_w    = pw_aid;
    rdata_w  = pw_addr ^ SEED;
    pend_w   = req_w && !rst_i;
    pw_aid   = aid_w;
    pw_addr  = addr_w;
    if (pend_w && we_w) begin
      if (n_w < 8) log_w[n_w] = addr_w;
      n_w++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [31:0] n);
    num_req_i = n;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done_o) break;
      tick();
    end
    chk(tag, done_o, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_i = 1'b1; start_i = 1'b0; num_req_i = '0;
    start_w = 1'b0; num_req_w = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    chk("rst_req", req_o, 0);      chk("rst_we", we_o, 0);
    chk("rst_addr", addr_o, 0);    chk("rst_wdata", wdata_o, 0);
    chk("rst_aid", aid_o, 0);      chk("rst_be", be_o, 4'hF);
    chk("rst_rready", rready_o, 1); chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);    chk("rst_err", err_cnt_o, 0);

    // zero-length run
    n_x = 0;
    start_run(0);
    chk("zero_done", done_o, 1);
    chk("zero_busy", busy_o, 0);
    chk("zero_req", req_o, 0);
    repeat (3) tick();
    chk("zero_xfers", n_x, 0);

    // basic run, 16 transfers per pass
    n_x = 0;
    start_run(16);
    chk("t2_req_rise", req_o, 1);  chk("t2_addr0", addr_o, 0);
    chk("t2_we0", we_o, 1);        chk("t2_wdata0", wdata_o, SEED);
    chk("t2_aid0", aid_o, 0);      chk("t2_busy", busy_o, 1);
    chk("t2_done0", done_o, 0);
    wait_done("t2_done", 200);
    chk("t2_done_lat", cyc - last_rsp_cyc, 1);
    chk("t2_busy_end", busy_o, 0);
    chk("t2_err", err_cnt_o, 0);
    chk("t2_nx", n_x, 32);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t2_addr%0d", i), log_addr[i], 32'((i % 16) * 4));
      chk($sformatf("t2_we%0d", i), log_we[i], (i < 16) ? 1'b1 : 1'b0);
      chk($sformatf("t2_aid%0d", i), log_aid[i], 5'(i % 16));
      if (i < 16) chk($sformatf("t2_wdata%0d", i), log_wdata[i], 32'((i % 16) * 4) ^ SEED);
    end

    // grant withheld: request must stay stable
    n_x = 0; gnt_en = 1'b0;
    start_run(2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_req%0d", k), req_o, 1);
      chk($sformatf("t3_addr%0d", k), addr_o, 0);
      chk($sformatf("t3_wdata%0d", k), wdata_o, SEED);
      chk($sformatf("t3_aid%0d", k), aid_o, 0);
      if (k < 4) tick();
    end
    gnt_en = 1'b1;
    tick();
    gnt_en = 1'b0;
    tick();
    chk("t3_single_xfer", n_x, 1);
    chk("t3_addr_next", addr_o, 32'h4);
    chk("t3_aid_next", aid_o, 1);
    chk("t3_wdata_next", wdata_o, 32'h4 ^ SEED);
    gnt_en = 1'b1;
    wait_done("t3_done", 100);
    chk("t3_err", err_cnt_o, 0);
    chk("t3_nx", n_x, 4);

    // responses withheld: outstanding limit
    n_x = 0; rsp_en = 1'b0;
    start_run(20);
    repeat (15) tick();
    chk("t4_nx_limit", n_x, 8);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_req_low%0d", k), req_o, 0);
      tick();
    end
    chk("t4_nx_still", n_x, 8);
    rsp_en = 1'b1;
    wait_done("t4_done", 400);
    chk("t4_err", err_cnt_o, 0);
    chk("t4_nx", n_x, 40);

    // corrupted read at 0x8 plus error response on write to 0x4
    corrupt_en = 1'b1; err_wr_en = 1'b1;
    start_run(4);
    wait_done("t5_done", 100);
    chk("t5_err", err_cnt_o, 2);
    corrupt_en = 1'b0; err_wr_en = 1'b0;

    // reset during read pass with responses pending
    start_run(16);
    for (int i = 0; i < 200; i++) begin
      if (busy_o && !we_o) break;
      tick();
    end
    chk("t6_read_phase", busy_o && !we_o, 1);
    rsp_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (q.size() >= 3) break;
      tick();
    end
    chk("t6_pending", q.size() >= 3, 1);
    gnt_en = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    chk("t6_busy_rst", busy_o, 0);
    chk("t6_req_rst", req_o, 0);
    chk("t6_err_rst", err_cnt_o, 0);
    chk("t6_addr_rst", addr_o, 0);
    gnt_en = 1'b1; rsp_en = 1'b1;
    repeat (12) tick();
    chk("t6_late_err", err_cnt_o, 0);
    chk("t6_late_busy", busy_o, 0);
    chk("t6_late_done", done_o, 0);
    n_x = 0;
    start_run(8);
    wait_done("t6_done", 200);
    chk("t6_err", err_cnt_o, 0);
    chk("t6_nx", n_x, 16);

    // address window wrap on the second instance
    n_w = 0;
    num_req_w = 6;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_w) break;
      tick();
    end
    chk("tw_done", done_w, 1);
    chk("tw_err", err_w_cnt, 0);
    chk("tw_nw", n_w, 6);
    chk("tw_a0", log_w[0], 32'h100);
    chk("tw_a1", log_w[1], 32'h104);
    chk("tw_a2", log_w[2], 32'h108);
    chk("tw_a3", log_w[3], 32'h10C);
    chk("tw_a4", log_w[4], 32'h100);
    chk("tw_a5", log_w[5], 32'h104);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/obi_traffic_gen.md
# obi_traffic_gen

Synthesizable single-port OBI manager traffic generator and checker. It replaces the behavioural random manager in crossbar and interconnect benches, and runs on FPGA or emulation, where class-based stimulus is unavailable. It runs a write pass followed by a read-back verify pass over a configurable address window, with up to NumMaxTrans transactions outstanding. It reports completion and a saturating error count.

## Interface
- AddrWidth, 32, OBI address width
- DataWidth, 32, OBI data width (multiple of 8)
- IdWidth, 5, OBI aid/rid width
- NumMaxTrans, 8, max outstanding transactions (power of 2, ≥2)
- MinAddr, 32'h0000_0000, first byte address of window (DataWidth/8-aligned)
- MaxAddr, 32'h0001_3000, exclusive end of window (aligned, > MinAddr)
- DataSeed, 32'hA5A5_5A5A, XOR pattern for write data
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  pulse: begin a run (ignored unless IDLE or DONE)
- num_req_i  in  32  transactions per pass; sampled on start_i
- busy_o  out  1  run in progress
- done_o  out  1  run finished; held until next start_i
- err_cnt_o  out  16  saturating error count; cleared on start_i
- req_o  out  1  OBI A-channel request
- gnt_i  in  1  OBI grant
- addr_o  out  AddrWidth  request address
- we_o  out  1  write enable
- be_o  out  DataWidth/8  byte enable (always all ones)
- wdata_o  out  DataWidth  write data
- aid_o  out  IdWidth  transaction ID
- rvalid_i  in  1  OBI response valid
- rready_o  out  1  response ready
- rdata_i  in  DataWidth  read data
- rid_i  in  IdWidth  response ID
- err_i  in  1  response error

## Operation
- FSM states: IDLE → WRITE → WDRAIN → READ → RDRAIN → DONE.
  - start_i in IDLE or DONE: latch num_req_i, reset the address pointer to MinAddr, clear err_cnt_o, go to WRITE.
  - With num_req_i = 0: go directly to DONE.
- WRITE/READ issue rules:
  - req_o=1 while the issued count < num_req and outstanding < NumMaxTrans.
  - Once req_o rises, it and addr/we/wdata/aid stay stable until gnt_i.
  - A transfer occurs on req_o & gnt_i. It increments the issued count and advances addr by DataWidth/8.
  - When the next address would be ≥ MaxAddr, it wraps to MinAddr.
- Write data: wdata = zero-extended addr XOR DataSeed (replicated to DataWidth).
- aid_o = issued count[IdWidth-1:0].
- Expected-value FIFO:
  - Depth NumMaxTrans, in order.
  - Each transfer pushes {addr, aid}.
  - Each response (rvalid_i & rready_o) pops it.
- Outstanding counter: +1 on transfer, −1 on response; both in the same cycle leaves it unchanged.
- WRITE → WDRAIN when issued == num_req.
- WDRAIN → READ when outstanding == 0. The address pointer resets to MinAddr and the issued count to 0.
- READ → RDRAIN → DONE under the same conditions.
- Error rules, +1 each, max one increment per response, saturating at 16'hFFFF:
  - err_i=1;
  - rid_i ≠ popped aid;
  - in the read pass only, rdata_i ≠ popped addr XOR DataSeed.
- A response with an empty FIFO counts as an error and is otherwise discarded.
- rst_i mid-run aborts immediately: FSM to IDLE, FIFO and counters cleared. In-flight responses arriving after reset are discarded without counting as errors.

## Timing
- Reset values: req_o=0, we_o=0, addr_o=MinAddr, wdata_o=0, aid_o=0, be_o=all ones, rready_o=1, busy_o=0, done_o=0, err_cnt_o=0.
- req_o first rises the cycle after start_i; addr_o, we_o, wdata_o and aid_o are registered outputs.
- With gnt_i=1 and outstanding < NumMaxTrans, one transfer per cycle (back-to-back).
- With a zero-latency response, a response in the same cycle as the transfer at the limit frees a slot in the following cycle. There is no combinational path from rvalid_i to req_o.
- done_o and busy_o=0 assert one cycle after the last response of the read pass.
- Checking is combinational on the response cycle; err_cnt_o updates the next cycle.

## Configuration
- OBI_TRAFFIC_GEN_RREADY_BP_EN:
  - Defined: rready_o is driven by bit 0 of a free-running 16-bit LFSR (seed 16'hACE1, reset on rst_i), exercising response back-pressure. All response accounting uses rvalid_i & rready_o.
  - Undefined: rready_o is constantly 1 and no LFSR is present.

## Test plan
- Memory model with always-gnt and 1-cycle rvalid, num_req=16, default window → 16 writes at 0x0,0x4…0x3C, then 16 reads; done_o=1, err_cnt_o=0.
- gnt_i held 0 for 5 cycles with req_o=1 → addr_o, wdata_o and aid_o unchanged across all 5 cycles; a single transfer on gnt.
- Slave withholds rvalid; num_req=20, NumMaxTrans=8 → exactly 8 transfers, then req_o=0 until the first response.
- Window MinAddr=0x100, MaxAddr=0x110, num_req=6 → addresses 0x100,0x104,0x108,0x10C,0x100,0x104.
- Memory model corrupts read data at 0x8 and returns err_i on one write, num_req=4 → err_cnt_o=2.
- rst_i asserted during READ with 3 outstanding, then start_i → clean run; late responses not counted; err_cnt_o=0.
